// File: rtl/key_frame_pkg.sv
// Shared constants and types for the key-frame UART parser.
// Frame: SYNC, CTRL{id,keys}, AUX{rsvd,rst,ready,skill}, CHK.
package key_frame_pkg;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] SALT = 8'h5A;

  typedef enum logic [1:0] {
    ID_NONE = 2'b00,
    ID_P1   = 2'b01,
    ID_P2   = 2'b10,
    ID_SYS  = 2'b11
  } id_e;

  typedef enum int {
    K_UP    = 0,
    K_DOWN  = 1,
    K_LEFT  = 2,
    K_RIGHT = 3,
    K_FIRE  = 4,
    K_SKILL = 5
  } key_bit_e;

  typedef enum logic [1:0] {
    S_HUNT,
    S_CTRL,
    S_AUX,
    S_CHK
  } state_e;

  typedef struct packed {
    logic [5:0] keys;
    logic [1:0] skill_sel;
    logic       ready;
  } player_t;

  function automatic logic [7:0] frame_chk(
    input logic [7:0] ctrl,
    input logic [7:0] aux
  );
    return ctrl ^ aux ^ SALT;
  endfunction

endpackage

// File: rtl/kfp_hold_timer.sv
// Retriggerable hold timer: expire pulses CYC cycles after the last load.
// Used only when KEY_FRAME_PARSER_TIMEOUT_EN is defined.
module kfp_hold_timer #(
  parameter int unsigned CYC = 100
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  output logic expire
);

  localparam int W = (CYC > 1) ? $clog2(CYC) : 1;

  logic [W-1:0] cnt;
  logic         active;

  // a fresh load always wins over a coincident expiry
  assign expire = active && (cnt == '0) && !load;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= W'(CYC - 1);
      active <= 1'b1;
    end else if (active) begin
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/key_frame_parser.sv
// 4-byte UART key frame parser for two players plus system frames.
// Key timeout enabled by defining KEY_FRAME_PARSER_TIMEOUT_EN.
module key_frame_parser
  import key_frame_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100000000,
  parameter int unsigned KEY_TIMEOUT_MS = 200,
  parameter int unsigned GAP_CYC        = 50000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [5:0] p1_keys,
  output logic [1:0] p1_skill_sel,
  output logic       p1_ready,
  output logic [5:0] p2_keys,
  output logic [1:0] p2_skill_sel,
  output logic       p2_ready,
  output logic       game_reset,
  output logic       frame_err
);

  localparam int GW = $clog2(GAP_CYC + 1);

  state_e      state;
  state_e      cur;
  logic [7:0]  ctrl_q;
  logic [7:0]  aux_q;
  logic [GW-1:0] gap_cnt;
  player_t     p1_q;
  player_t     p2_q;
  player_t     upd;
  id_e         id;
  logic        gap_exp;
  logic        frame_ok;
  logic        accept;
  logic        t1_exp;
  logic        t2_exp;

  // an expiring gap is seen as HUNT so a byte in that cycle is not lost
  assign gap_exp = (state != S_HUNT) && (gap_cnt == GW'(GAP_CYC));
  assign cur     = gap_exp ? S_HUNT : state;

  assign id       = id_e'(ctrl_q[7:6]);
  assign frame_ok = (rx_data == frame_chk(ctrl_q, aux_q))
                 && (id != ID_NONE)
                 && (aux_q[7:4] == 4'h0);
  assign accept   = rx_valid && (cur == S_CHK) && frame_ok;

  assign upd = '{keys:      ctrl_q[5:0],
                 skill_sel: aux_q[1:0],
                 ready:     aux_q[2]};

`ifdef KEY_FRAME_PARSER_TIMEOUT_EN
  localparam int unsigned HOLD_CYC = CLK_HZ / 1000 * KEY_TIMEOUT_MS;

  kfp_hold_timer #(.CYC(HOLD_CYC)) u_p1_timer (
    .clk    (clk),
    .rstn   (rstn),
    .load   (accept && (id == ID_P1)),
    .expire (t1_exp)
  );

  kfp_hold_timer #(.CYC(HOLD_CYC)) u_p2_timer (
    .clk    (clk),
    .rstn   (rstn),
    .load   (accept && (id == ID_P2)),
    .expire (t2_exp)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{CLK_HZ, KEY_TIMEOUT_MS};
  assign t1_exp = 1'b0;
  assign t2_exp = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_HUNT;
      ctrl_q     <= '0;
      aux_q      <= '0;
      gap_cnt    <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      game_reset <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      game_reset <= 1'b0;
      frame_err  <= gap_exp;
      if (rx_valid || cur == S_HUNT) gap_cnt <= '0;
      else                           gap_cnt <= gap_cnt + GW'(1);
      if (t1_exp) p1_q.keys <= '0;
      if (t2_exp) p2_q.keys <= '0;
      if (rx_valid) begin
        unique case (cur)
          S_HUNT: state <= (rx_data == SYNC) ? S_CTRL : S_HUNT;
          S_CTRL: begin
            ctrl_q <= rx_data;
            state  <= S_AUX;
          end
          S_AUX: begin
            aux_q <= rx_data;
            state <= S_CHK;
          end
          S_CHK: begin
            state <= S_HUNT;
            if (!frame_ok) frame_err <= 1'b1;
            else begin
              unique case (id)
                ID_P1: p1_q <= upd;
                ID_P2: p2_q <= upd;
                ID_SYS: begin
                  if (aux_q[3]) begin
                    game_reset <= 1'b1;
                    p1_q.keys  <= '0;
                    p1_q.ready <= 1'b0;
                    p2_q.keys  <= '0;
                    p2_q.ready <= 1'b0;
                  end
                end
                ID_NONE: ;
              endcase
            end
          end
        endcase
      end else begin
        state <= cur;
      end
    end
  end

  assign p1_keys      = p1_q.keys;
  assign p1_skill_sel = p1_q.skill_sel;
  assign p1_ready     = p1_q.ready;
  assign p2_keys      = p2_q.keys;
  assign p2_skill_sel = p2_q.skill_sel;
  assign p2_ready     = p2_q.ready;

endmodule

// File: tb/tb_key_frame_parser.sv
// Directed self-checking bench for key_frame_parser.
// Define KEY_FRAME_PARSER_TIMEOUT_EN to exercise the key timeout.
module tb_key_frame_parser;

  localparam int unsigned CLK_HZ  = 100000;
  localparam int unsigned TMO_MS  = 1;
  localparam int unsigned GAP     = 20;
  localparam int unsigned HOLD    = 100;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [5:0] p1_keys, p2_keys;
  logic [1:0] p1_skill_sel, p2_skill_sel;
  logic       p1_ready, p2_ready;
  logic       game_reset, frame_err;

  int checks = 0;
  int errors = 0;

  key_frame_parser #(
    .CLK_HZ         (CLK_HZ),
    .KEY_TIMEOUT_MS (TMO_MS),
    .GAP_CYC        (GAP)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .p1_keys      (p1_keys),
    .p1_skill_sel (p1_skill_sel),
    .p1_ready     (p1_ready),
    .p2_keys      (p2_keys),
    .p2_skill_sel (p2_skill_sel),
    .p2_ready     (p2_ready),
    .game_reset   (game_reset),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // {keys, skill_sel, ready}
  function automatic logic [8:0] p1_bus();
    return {p1_keys, p1_skill_sel, p1_ready};
  endfunction

  function automatic logic [8:0] p2_bus();
    return {p2_keys, p2_skill_sel, p2_ready};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic frame(input logic [7:0] c,
                       input logic [7:0] a,
                       input logic [7:0] k);
    send(8'hA5);
    send(c);
    send(a);
    send(k);
  endtask

  int  seen;
  logic any_err;

  initial begin
    tick(3);
    check("rst_p1", {23'd0, p1_bus()}, 32'h0);
    check("rst_p2", {23'd0, p2_bus()}, 32'h0);
    check("rst_pulses", {30'd0, game_reset, frame_err}, 32'h0);
    rstn = 1'b1;
    tick(2);

    // P2: fire, ready, skill 1 -> {010000,01,1}
    frame(8'h90, 8'h05, 8'hCF);
    check("p2_fire", {23'd0, p2_bus()}, {23'd0, 9'b010000_01_1});
    check("p2_p1_clear", {23'd0, p1_bus()}, 32'h0);

    // P1: up, ready, skill 2
    frame(8'h41, 8'h06, 8'h1D);
    check("p1_up", {23'd0, p1_bus()}, {23'd0, 9'b000001_10_1});
    check("p1_p2_hold", {23'd0, p2_bus()}, {23'd0, 9'b010000_01_1});
    check("p1_no_err", {31'd0, frame_err}, 32'h0);

    // bad checksum
    frame(8'h41, 8'h06, 8'h00);
    check("badchk_err", {31'd0, frame_err}, 32'h1);
    check("badchk_p1", {23'd0, p1_bus()}, {23'd0, 9'b000001_10_1});
    tick(1);
    check("badchk_pulse", {31'd0, frame_err}, 32'h0);

    // system reset frame
    frame(8'hC0, 8'h08, 8'h92);
    check("sys_greset", {31'd0, game_reset}, 32'h1);
    check("sys_p1", {23'd0, p1_bus()}, {23'd0, 9'b000000_10_0});
    check("sys_p2", {23'd0, p2_bus()}, {23'd0, 9'b000000_01_0});
    tick(1);
    check("sys_pulse", {31'd0, game_reset}, 32'h0);

    // system frame without rst bit: fields ignored
    frame(8'hC3, 8'h04, 8'h9D);
    check("sys_norst_gr", {30'd0, game_reset, frame_err}, 32'h0);
    check("sys_norst_p1", {23'd0, p1_bus()}, {23'd0, 9'b000000_10_0});

    // reserved AUX bits set
    frame(8'h41, 8'h16, 8'h0D);
    check("rsvd_err", {31'd0, frame_err}, 32'h1);
    // id 00
    frame(8'h01, 8'h00, 8'h5B);
    check("id0_err", {31'd0, frame_err}, 32'h1);
    check("id0_p1", {23'd0, p1_bus()}, {23'd0, 9'b000000_10_0});

    // junk in HUNT, then A5 used as CTRL data
    any_err = 1'b0;
    send(8'h00); any_err |= frame_err;
    send(8'h5A); any_err |= frame_err;
    send(8'hFF); any_err |= frame_err;
    check("hunt_junk", {31'd0, any_err}, 32'h0);
    frame(8'hA5, 8'h00, 8'hFF);
    check("a5_data", {23'd0, p2_bus()}, {23'd0, 9'b100101_00_0});

    // inter-byte gap expiry
    send(8'hA5);
    send(8'h41);
    seen = 0;
    for (int i = 1; i <= int'(GAP) + 4; i++) begin
      tick(1);
      if (frame_err && seen == 0) seen = i;
    end
    check("gap_err_cyc", seen, GAP + 1);
    frame(8'h42, 8'h04, 8'h1C);
    check("gap_recover", {23'd0, p1_bus()}, {23'd0, 9'b000010_00_1});

`ifdef KEY_FRAME_PARSER_TIMEOUT_EN
    tick(HOLD - 1);
    check("tmo_hold", {26'd0, p1_keys}, 32'h02);
    tick(1);
    check("tmo_clear", {26'd0, p1_keys}, 32'h0);
    check("tmo_ready", {31'd0, p1_ready}, 32'h1);
`else
    tick(HOLD + 50);
    check("no_tmo_keys", {26'd0, p1_keys}, 32'h02);
    check("no_tmo_ready", {31'd0, p1_ready}, 32'h1);
`endif

    // reset in the middle of a frame
    frame(8'h41, 8'h06, 8'h1D);
    send(8'hA5);
    send(8'h42);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_p1", {23'd0, p1_bus()}, 32'h0);
    check("mid_rst_p2", {23'd0, p2_bus()}, 32'h0);
    check("mid_rst_pls", {30'd0, game_reset, frame_err}, 32'h0);
    any_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      any_err |= frame_err;
    end
    rstn = 1'b1;
    for (int i = 0; i < int'(GAP) + 5; i++) begin
      tick(1);
      any_err |= frame_err;
    end
    check("mid_rst_noerr", {31'd0, any_err}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
